// File: rtl/gb_mmu_if.sv
// Purpose: CPU memory port, shared region bus, OAM port and status outputs of gb_mmu.
// Ports: cpu_* from the CPU core; bus_*, *_wren and *_q for the external regions;
//        oam_* for OAM; ie, boot_rom_en and dma_active are status outputs.
interface gb_mmu_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wren;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        cart_wren;
  logic        vram_wren;
  logic        wram_wren;
  logic        io_wren;
  logic [7:0]  cart_q;
  logic [7:0]  vram_q;
  logic [7:0]  wram_q;
  logic [7:0]  io_q;
  logic [7:0]  boot_rom_q;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_wren;
  logic [7:0]  oam_q;
  logic [7:0]  ie;
  logic        boot_rom_en;
  logic        dma_active;

  // master: the MMU itself
  modport master (
    input  cpu_addr, cpu_wdata, cpu_wren,
    input  cart_q, vram_q, wram_q, io_q, boot_rom_q, oam_q,
    output cpu_rdata, bus_addr, bus_wdata,
    output cart_wren, vram_wren, wram_wren, io_wren,
    output oam_addr, oam_wdata, oam_wren,
    output ie, boot_rom_en, dma_active
  );

  // slave: CPU core plus the memory regions around the MMU
  modport slave (
    output cpu_addr, cpu_wdata, cpu_wren,
    output cart_q, vram_q, wram_q, io_q, boot_rom_q, oam_q,
    input  cpu_rdata, bus_addr, bus_wdata,
    input  cart_wren, vram_wren, wram_wren, io_wren,
    input  oam_addr, oam_wdata, oam_wren,
    input  ie, boot_rom_en, dma_active
  );
endinterface

// File: rtl/gb_mmu.sv
// Purpose: Game Boy address decode/read mux with boot overlay (FF50), HRAM, IE and OAM DMA (FF46).
// Latency: reads combinational (0 cycles); writes land on the same clock edge as cpu_wren.
// Backpressure: none; while DMA runs, non-HRAM/IE CPU reads return 0xFF and writes are dropped.
// Ports: clock, reset (sync, active-high); mem = gb_mmu_if.master (CPU port, region bus, OAM, status).
// Option: define MMU_ECHO_RAM_EN to mirror E000-FDFF onto C000-DDFF for the CPU.
module gb_mmu #(
  parameter int DMA_CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN             = 160
) (
  input  logic      clock,
  input  logic      reset,
  gb_mmu_if.master  mem
);

  localparam logic [3:0] LAST_CYC  = 4'(DMA_CYCLES_PER_BYTE - 1);
  localparam logic [7:0] LAST_BYTE = 8'(DMA_LEN - 1);

  typedef enum logic {DMA_IDLE, DMA_XFER} dma_state_t;

  typedef enum logic [3:0] {
    SEL_CART, SEL_BOOT, SEL_VRAM, SEL_WRAM, SEL_OAM, SEL_ZERO,
    SEL_NONE, SEL_IO, SEL_DMA, SEL_BOOTREG, SEL_HRAM, SEL_IE
  } sel_t;

  dma_state_t  state_q, state_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  cyc_q, cyc_d;
  logic [7:0]  dma_src_q;
  logic [7:0]  ie_q;
  logic        boot_rom_en_q;
  logic [7:0]  hram [0:126];

  sel_t        cpu_sel;
  logic [15:0] cpu_bus_addr;
  logic [7:0]  dma_page;
  logic [7:0]  dma_rdata;
  logic        dma_active;
  logic        cpu_we;
  logic        cpu_owns;
  logic        dma_start;
  logic        dma_wr;

  assign dma_active = (state_q == DMA_XFER);
  assign cpu_we     = mem.cpu_wren && !reset;
  assign cpu_owns   = !dma_active;
  assign dma_start  = cpu_we && (cpu_sel == SEL_DMA);
  // A restarting FF46 write pre-empts the byte that would otherwise land this cycle.
  assign dma_wr     = dma_active && (cyc_q == LAST_CYC) && !reset && !dma_start;

  // CPU-side region decode.
  always_comb begin
    cpu_sel      = SEL_NONE;
    cpu_bus_addr = mem.cpu_addr;
    if (mem.cpu_addr[15:8] == 8'h00 && boot_rom_en_q)      cpu_sel = SEL_BOOT;
    else if (!mem.cpu_addr[15])                            cpu_sel = SEL_CART;
    else if (mem.cpu_addr[15:13] == 3'b100)                cpu_sel = SEL_VRAM;
    else if (mem.cpu_addr[15:13] == 3'b101)                cpu_sel = SEL_CART;
    else if (mem.cpu_addr[15:13] == 3'b110)                cpu_sel = SEL_WRAM;
    else if (mem.cpu_addr < 16'hFE00) begin
`ifdef MMU_ECHO_RAM_EN
      cpu_sel      = SEL_WRAM;
      cpu_bus_addr = mem.cpu_addr - 16'h2000;
`else
      cpu_sel      = SEL_NONE;
`endif
    end
    else if (mem.cpu_addr < 16'hFEA0)                      cpu_sel = SEL_OAM;
    else if (mem.cpu_addr[15:8] == 8'hFE)                  cpu_sel = SEL_ZERO;
    else if (mem.cpu_addr == 16'hFF46)                     cpu_sel = SEL_DMA;
    else if (mem.cpu_addr == 16'hFF50)                     cpu_sel = SEL_BOOTREG;
    else if (!mem.cpu_addr[7])                             cpu_sel = SEL_IO;
    else if (mem.cpu_addr == 16'hFFFF)                     cpu_sel = SEL_IE;
    else                                                   cpu_sel = SEL_HRAM;
  end

  // Pages E0-FF fold down onto C0-DF, so DMA can only source cart/vram/wram/boot.
  assign dma_page = (dma_src_q >= 8'hE0) ? (dma_src_q - 8'h20) : dma_src_q;

  always_comb begin
    dma_rdata = mem.wram_q;
    if (dma_page == 8'h00 && boot_rom_en_q) dma_rdata = mem.boot_rom_q;
    else if (!dma_page[7])                  dma_rdata = mem.cart_q;
    else if (dma_page[7:5] == 3'b100)       dma_rdata = mem.vram_q;
    else if (dma_page[7:5] == 3'b101)       dma_rdata = mem.cart_q;
  end

  assign mem.bus_addr  = dma_active ? {dma_page, byte_idx_q} : cpu_bus_addr;
  assign mem.bus_wdata = mem.cpu_wdata;
  assign mem.cart_wren = cpu_we && cpu_owns && (cpu_sel == SEL_CART || cpu_sel == SEL_BOOT);
  assign mem.vram_wren = cpu_we && cpu_owns && (cpu_sel == SEL_VRAM);
  assign mem.wram_wren = cpu_we && cpu_owns && (cpu_sel == SEL_WRAM);
  assign mem.io_wren   = cpu_we && cpu_owns && (cpu_sel == SEL_IO);
  assign mem.oam_wren  = dma_wr || (cpu_we && cpu_owns && (cpu_sel == SEL_OAM));
  assign mem.oam_addr  = dma_active ? byte_idx_q : mem.cpu_addr[7:0];
  assign mem.oam_wdata = dma_active ? dma_rdata : mem.cpu_wdata;
  assign mem.ie          = ie_q;
  assign mem.boot_rom_en = boot_rom_en_q;
  assign mem.dma_active  = dma_active;

  // CPU read mux; DMA owns everything except HRAM and IE.
  always_comb begin
    mem.cpu_rdata = 8'hFF;
    if (cpu_owns || cpu_sel == SEL_HRAM || cpu_sel == SEL_IE) begin
      case (cpu_sel)
        SEL_CART:    mem.cpu_rdata = mem.cart_q;
        SEL_BOOT:    mem.cpu_rdata = mem.boot_rom_q;
        SEL_VRAM:    mem.cpu_rdata = mem.vram_q;
        SEL_WRAM:    mem.cpu_rdata = mem.wram_q;
        SEL_OAM:     mem.cpu_rdata = mem.oam_q;
        SEL_ZERO:    mem.cpu_rdata = 8'h00;
        SEL_IO:      mem.cpu_rdata = mem.io_q;
        SEL_DMA:     mem.cpu_rdata = dma_src_q;
        SEL_HRAM:    mem.cpu_rdata = hram[mem.cpu_addr[6:0]];
        SEL_IE:      mem.cpu_rdata = ie_q;
        default:     mem.cpu_rdata = 8'hFF;
      endcase
    end
  end

  // DMA next state: each byte holds for DMA_CYCLES_PER_BYTE cycles, last byte returns to IDLE.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    cyc_d      = cyc_q;
    if (dma_start) begin
      state_d    = DMA_XFER;
      byte_idx_d = 8'h00;
      cyc_d      = 4'h0;
    end else if (state_q == DMA_XFER) begin
      if (cyc_q == LAST_CYC) begin
        cyc_d = 4'h0;
        if (byte_idx_q == LAST_BYTE) begin
          state_d    = DMA_IDLE;
          byte_idx_d = 8'h00;
        end else begin
          byte_idx_d = byte_idx_q + 8'h01;
        end
      end else begin
        cyc_d = cyc_q + 4'h1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= DMA_IDLE;
      byte_idx_q    <= 8'h00;
      cyc_q         <= 4'h0;
      dma_src_q     <= 8'h00;
      ie_q          <= 8'h00;
      boot_rom_en_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      cyc_q      <= cyc_d;
      if (dma_start)
        dma_src_q <= mem.cpu_wdata;
      if (cpu_we && cpu_sel == SEL_IE)
        ie_q <= mem.cpu_wdata;
      // Overlay can only be switched off; a zero write is ignored.
      if (cpu_we && cpu_owns && cpu_sel == SEL_BOOTREG && mem.cpu_wdata != 8'h00)
        boot_rom_en_q <= 1'b0;
    end
  end

  // HRAM keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (cpu_we && cpu_sel == SEL_HRAM)
      hram[mem.cpu_addr[6:0]] <= mem.cpu_wdata;
  end

endmodule

// File: tb/tb_gb_mmu.sv
// Purpose: self-checking bench for gb_mmu: decode, boot overlay, HRAM/IE, OAM DMA, restart/abort, echo.
// Ports: none; drives a gb_mmu_if instance and models region read data from bus_addr.
module tb_gb_mmu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gb_mmu_if bus_if ();

  gb_mmu #(.DMA_CYCLES_PER_BYTE(4), .DMA_LEN(160)) dut (
    .clock (clock),
    .reset (reset),
    .mem   (bus_if)
  );

  // Region models: each region returns a distinct function of the low address byte.
  assign bus_if.cart_q     = bus_if.bus_addr[7:0] ^ 8'h5A;
  assign bus_if.vram_q     = bus_if.bus_addr[7:0] ^ 8'h33;
  assign bus_if.wram_q     = bus_if.bus_addr[7:0];
  assign bus_if.boot_rom_q = bus_if.bus_addr[7:0] ^ 8'hB0;
  assign bus_if.io_q       = 8'h10;
  assign bus_if.oam_q      = 8'h4F;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  oa;
    logic [7:0]  od;
    logic [15:0] ba;
  } pulse_t;
  pulse_t exp_q [$];

  function automatic logic [4:0] strobes();
    return {bus_if.cart_wren, bus_if.vram_wren, bus_if.wram_wren, bus_if.io_wren, bus_if.oam_wren};
  endfunction

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    bus_if.cpu_addr  = a;
    bus_if.cpu_wdata = d;
    bus_if.cpu_wren  = 1'b1;
    @(negedge clock);
    bus_if.cpu_wren  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_if.cpu_addr  = 16'h8000;
    bus_if.cpu_wdata = 8'h11;
    bus_if.cpu_wren  = 1'b1;
    #1;
    n_cmp++;
    if (strobes() !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes got %b want 00000", strobes());
    end
    @(negedge clock);
    bus_if.cpu_wren = 1'b0;
    n_cmp++;
    if ({bus_if.boot_rom_en, bus_if.ie, bus_if.dma_active} !== {1'b1, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL reset_state got boot=%b ie=%h dma=%b want 1 00 0",
                        bus_if.boot_rom_en, bus_if.ie, bus_if.dma_active);
    end
    reset = 1'b0;
    bus_if.cpu_addr = 16'hFF46;
    #1;
    n_cmp++;
    if (bus_if.cpu_rdata !== 8'h00) begin
      n_err++; $display("FAIL reset_ff46 got %h want 00", bus_if.cpu_rdata);
    end
  endtask

  task automatic test_boot_overlay();
    @(negedge clock);
    bus_if.cpu_addr = 16'h0050;
    #1;
    n_cmp++;
    if (bus_if.cpu_rdata !== (8'h50 ^ 8'hB0)) begin
      n_err++; $display("FAIL boot_read got %h want %h", bus_if.cpu_rdata, 8'h50 ^ 8'hB0);
    end
    bus_if.cpu_wdata = 8'h99;
    bus_if.cpu_wren  = 1'b1;
    #1;
    n_cmp++;
    if (strobes() !== 5'b10000) begin
      n_err++; $display("FAIL boot_write_to_cart got %b want 10000", strobes());
    end
    @(negedge clock);
    bus_if.cpu_wren = 1'b0;
    cpu_write(16'hFF50, 8'h01);
    bus_if.cpu_addr = 16'h0050;
    #1;
    n_cmp++;
    if ({bus_if.boot_rom_en, bus_if.cpu_rdata} !== {1'b0, 8'h50 ^ 8'h5A}) begin
      n_err++; $display("FAIL boot_off got en=%b rd=%h want 0 %h",
                        bus_if.boot_rom_en, bus_if.cpu_rdata, 8'h50 ^ 8'h5A);
    end
    cpu_write(16'hFF50, 8'h00);
    #1;
    n_cmp++;
    if ({bus_if.boot_rom_en, bus_if.cpu_rdata} !== {1'b0, 8'hFF}) begin
      n_err++; $display("FAIL boot_sticky got en=%b ff50=%h want 0 ff",
                        bus_if.boot_rom_en, bus_if.cpu_rdata);
    end
  endtask

  task automatic test_region_strobes();
    logic [15:0] addrs [7];
    logic [4:0]  want  [7];
    addrs[0] = 16'h8123; want[0] = 5'b01000;
    addrs[1] = 16'hA010; want[1] = 5'b10000;
    addrs[2] = 16'hC005; want[2] = 5'b00100;
    addrs[3] = 16'hFF01; want[3] = 5'b00010;
    addrs[4] = 16'hFE12; want[4] = 5'b00001;
    addrs[5] = 16'hFEA0; want[5] = 5'b00000;
    addrs[6] = 16'hFF50; want[6] = 5'b00000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      bus_if.cpu_addr  = addrs[i];
      bus_if.cpu_wdata = 8'hA5;
      bus_if.cpu_wren  = 1'b1;
      #1;
      n_cmp++;
      if (strobes() !== want[i]) begin
        n_err++; $display("FAIL strobe_%h got %b want %b", addrs[i], strobes(), want[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus_if.bus_addr, bus_if.bus_wdata} !== {16'h8123, 8'hA5}) begin
          n_err++; $display("FAIL vram_bus got %h/%h want 8123/a5", bus_if.bus_addr, bus_if.bus_wdata);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if ({bus_if.oam_addr, bus_if.oam_wdata} !== {8'h12, 8'hA5}) begin
          n_err++; $display("FAIL oam_cpu got %h/%h want 12/a5", bus_if.oam_addr, bus_if.oam_wdata);
        end
      end
      @(negedge clock);
      bus_if.cpu_wren = 1'b0;
      #1;
      n_cmp++;
      if (strobes() !== 5'b0) begin
        n_err++; $display("FAIL strobe_len_%h got %b want 00000", addrs[i], strobes());
      end
    end
    bus_if.cpu_addr = 16'hFEA0;
    #1;
    n_cmp++;
    if (bus_if.cpu_rdata !== 8'h00) begin
      n_err++; $display("FAIL fea0_read got %h want 00", bus_if.cpu_rdata);
    end
    bus_if.cpu_addr = 16'h8123;
    #1;
    n_cmp++;
    if (bus_if.cpu_rdata !== (8'h23 ^ 8'h33)) begin
      n_err++; $display("FAIL vram_read got %h want %h", bus_if.cpu_rdata, 8'h23 ^ 8'h33);
    end
  endtask

  task automatic test_hram_ie();
    logic [15:0] ra [3];
    logic [7:0]  rv [3];
    cpu_write(16'hFF80, 8'h3C);
    cpu_write(16'hFFFF, 8'h1F);
    cpu_write(16'hFFFE, 8'hC3);
    ra[0] = 16'hFF80; rv[0] = 8'h3C;
    ra[1] = 16'hFFFF; rv[1] = 8'h1F;
    ra[2] = 16'hFFFE; rv[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      bus_if.cpu_addr = ra[i];
      #1;
      n_cmp++;
      if (bus_if.cpu_rdata !== rv[i]) begin
        n_err++; $display("FAIL hram_ie_%h got %h want %h", ra[i], bus_if.cpu_rdata, rv[i]);
      end
    end
    n_cmp++;
    if (bus_if.ie !== 8'h1F) begin
      n_err++; $display("FAIL ie_port got %h want 1f", bus_if.ie);
    end
  endtask

  task automatic test_echo();
    @(negedge clock);
    bus_if.cpu_addr  = 16'hE010;
    bus_if.cpu_wdata = 8'h77;
    bus_if.cpu_wren  = 1'b1;
    #1;
`ifdef MMU_ECHO_RAM_EN
    n_cmp++;
    if ({strobes(), bus_if.bus_addr, bus_if.cpu_rdata} !== {5'b00100, 16'hC010, 8'h10}) begin
      n_err++; $display("FAIL echo got strb=%b bus=%h rd=%h want 00100 c010 10",
                        strobes(), bus_if.bus_addr, bus_if.cpu_rdata);
    end
`else
    n_cmp++;
    if ({strobes(), bus_if.cpu_rdata} !== {5'b00000, 8'hFF}) begin
      n_err++; $display("FAIL echo_off got strb=%b rd=%h want 00000 ff", strobes(), bus_if.cpu_rdata);
    end
`endif
    @(negedge clock);
    bus_if.cpu_wren = 1'b0;
  endtask

  task automatic test_dma();
    pulse_t e;
    int cnt;
    exp_q.delete();
    for (int i = 0; i < 160; i++)
      exp_q.push_back('{cyc: 4*i + 3, oa: 8'(i), od: 8'(i), ba: 16'hC100 + 16'(i)});
    cpu_write(16'hFF46, 8'hC1);
    cnt = 0;
    while (bus_if.dma_active === 1'b1 && cnt < 2000) begin
      if (bus_if.oam_wren === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL dma_extra_pulse cyc=%0d oa=%h", cnt, bus_if.oam_addr);
        end else begin
          e = exp_q.pop_front();
          if (cnt != e.cyc || bus_if.oam_addr !== e.oa || bus_if.oam_wdata !== e.od || bus_if.bus_addr !== e.ba) begin
            n_err++; $display("FAIL dma_pulse got cyc=%0d oa=%h od=%h ba=%h want %0d %h %h %h",
                              cnt, bus_if.oam_addr, bus_if.oam_wdata, bus_if.bus_addr, e.cyc, e.oa, e.od, e.ba);
          end
        end
      end
      if (cnt == 100) begin
        bus_if.cpu_addr = 16'hC000;
        bus_if.cpu_wren = 1'b1;
        #1;
        n_cmp++;
        if ({bus_if.cpu_rdata, strobes()} !== {8'hFF, 5'b0}) begin
          n_err++; $display("FAIL dma_cpu_blocked got rd=%h strb=%b want ff 00000", bus_if.cpu_rdata, strobes());
        end
        bus_if.cpu_wren = 1'b0;
        bus_if.cpu_addr = 16'hFF80;
        #1;
        n_cmp++;
        if (bus_if.cpu_rdata !== 8'h3C) begin
          n_err++; $display("FAIL dma_hram got %h want 3c", bus_if.cpu_rdata);
        end
      end
      @(negedge clock);
      cnt++;
    end
    n_cmp++;
    if (cnt != 640 || exp_q.size() != 0) begin
      n_err++; $display("FAIL dma_length got %0d cycles %0d missing want 640 0", cnt, exp_q.size());
    end
    bus_if.cpu_addr = 16'hFF46;
    #1;
    n_cmp++;
    if (bus_if.cpu_rdata !== 8'hC1) begin
      n_err++; $display("FAIL ff46_read got %h want c1", bus_if.cpu_rdata);
    end
  endtask

  task automatic test_dma_restart();
    pulse_t e;
    int cnt;
    int popped;
    int extra;
    exp_q.delete();
    for (int i = 0; i < 50; i++)
      exp_q.push_back('{cyc: 4*i + 3, oa: 8'(i), od: 8'(i), ba: 16'hC100 + 16'(i)});
    cpu_write(16'hFF46, 8'hC1);
    cnt = 0; popped = 0;
    while (popped < 50 && cnt < 1000) begin
      if (bus_if.oam_wren === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        popped++;
        n_cmp++;
        if (cnt != e.cyc || bus_if.oam_addr !== e.oa || bus_if.bus_addr !== e.ba) begin
          n_err++; $display("FAIL restart_pre got cyc=%0d oa=%h ba=%h want %0d %h %h",
                            cnt, bus_if.oam_addr, bus_if.bus_addr, e.cyc, e.oa, e.ba);
        end
      end
      @(negedge clock);
      cnt++;
    end
    // Now in the first cycle of byte 50: rewrite FF46.
    bus_if.cpu_addr  = 16'hFF46;
    bus_if.cpu_wdata = 8'hC2;
    bus_if.cpu_wren  = 1'b1;
    @(negedge clock);
    bus_if.cpu_wren = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 80; i++)
      exp_q.push_back('{cyc: 4*i + 3, oa: 8'(i), od: 8'(i), ba: 16'hC200 + 16'(i)});
    cnt = 0; popped = 0;
    while (popped < 80 && cnt < 1000) begin
      if (bus_if.oam_wren === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        popped++;
        n_cmp++;
        if (cnt != e.cyc || bus_if.oam_addr !== e.oa || bus_if.oam_wdata !== e.od || bus_if.bus_addr !== e.ba) begin
          n_err++; $display("FAIL restart_post got cyc=%0d oa=%h od=%h ba=%h want %0d %h %h %h",
                            cnt, bus_if.oam_addr, bus_if.oam_wdata, bus_if.bus_addr, e.cyc, e.oa, e.od, e.ba);
        end
      end
      @(negedge clock);
      cnt++;
    end
    n_cmp++;
    if (popped != 80) begin
      n_err++; $display("FAIL restart_count got %0d want 80", popped);
    end
    // Byte 80: abort with reset.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({bus_if.dma_active, bus_if.boot_rom_en} !== 2'b01) begin
      n_err++; $display("FAIL abort_state got dma=%b boot=%b want 0 1", bus_if.dma_active, bus_if.boot_rom_en);
    end
    extra = 0;
    for (int i = 0; i < 700; i++) begin
      if (bus_if.oam_wren !== 1'b0 || bus_if.dma_active !== 1'b0) extra++;
      @(negedge clock);
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_dma_remap();
    int cnt;
    cpu_write(16'hFF46, 8'hE3);
    bus_if.cpu_addr = 16'hFF46;
    #1;
    n_cmp++;
    if (bus_if.cpu_rdata !== 8'hFF) begin
      n_err++; $display("FAIL ff46_during_dma got %h want ff", bus_if.cpu_rdata);
    end
    cnt = 0;
    while (bus_if.oam_wren !== 1'b1 && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    n_cmp++;
    if (cnt != 3 || bus_if.bus_addr !== 16'hC300 || bus_if.oam_addr !== 8'h00 || bus_if.oam_wdata !== 8'h00) begin
      n_err++; $display("FAIL dma_remap got cyc=%0d ba=%h oa=%h od=%h want 3 c300 00 00",
                        cnt, bus_if.bus_addr, bus_if.oam_addr, bus_if.oam_wdata);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus_if.cpu_addr  = 16'h0000;
    bus_if.cpu_wdata = 8'h00;
    bus_if.cpu_wren  = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_boot_overlay();
    test_region_strobes();
    test_hram_ie();
    test_echo();
    test_dma();
    test_dma_restart();
    test_dma_remap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
